result_dispatcher: RTL and testbench

- Return-path counterpart of the two-slave input arbiter.
- Pops processed words from the accelerator's result FIFO and routes each word to master port 0 or 1 according to its source tag.
- Uses a valid/ready handshake on each master port.
- Counts words delivered per master and pulses that master's completion flag when a frame of FRAME_LEN words has been returned.

---
 rtl/result_dispatcher_pkg.sv | 23 ++
 rtl/result_dispatcher_if.sv | 44 ++++
 rtl/dispatch_frame_counter.sv | 23 ++
 rtl/result_dispatcher.sv | 154 +++++++++++++++
 tb/tb_result_dispatcher.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/result_dispatcher_pkg.sv
// Shared types and default widths for the result dispatcher.
package result_dispatcher_pkg;

    localparam int unsigned RD_DW     = 32;
    localparam int unsigned RD_PVW    = 8;
    localparam int unsigned RD_WORD_W = 1 + 2 + RD_PVW + RD_DW;

    typedef struct packed {
        logic              src;
        logic [1:0]        mode;
        logic [RD_PVW-1:0] proc_val;
        logic [RD_DW-1:0]  data;
    } res_word_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StCapture,
        StSend,
        StDone
    } disp_state_t;

endpackage

// File: rtl/result_dispatcher_if.sv
// Result FIFO pop side plus the two return-path master ports of the dispatcher.
interface result_dispatcher_if
    import result_dispatcher_pkg::*;
#(
    parameter int unsigned DW  = RD_DW,
    parameter int unsigned PVW = RD_PVW
);
    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DW+PVW+2:0]     fifo_dout;

    logic [DW-1:0]         mstr0_data;
    logic [1:0]            mstr0_mode;
    logic [PVW-1:0]        mstr0_proc_val;
    logic                  mstr0_data_valid;
    logic                  mstr0_ready;
    logic                  mstr0_cmplt;

    logic [DW-1:0]         mstr1_data;
    logic [1:0]            mstr1_mode;
    logic [PVW-1:0]        mstr1_proc_val;
    logic                  mstr1_data_valid;
    logic                  mstr1_ready;
    logic                  mstr1_cmplt;

    logic                  drop_err;

    modport master (
        input  fifo_empty, fifo_dout, mstr0_ready, mstr1_ready,
        output fifo_rd_en,
        output mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_data_valid, mstr0_cmplt,
        output mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_data_valid, mstr1_cmplt,
        output drop_err
    );

    modport slave (
        output fifo_empty, fifo_dout, mstr0_ready, mstr1_ready,
        input  fifo_rd_en,
        input  mstr0_data, mstr0_mode, mstr0_proc_val, mstr0_data_valid, mstr0_cmplt,
        input  mstr1_data, mstr1_mode, mstr1_proc_val, mstr1_data_valid, mstr1_cmplt,
        input  drop_err
    );

endinterface

// File: rtl/dispatch_frame_counter.sv
// Per-master delivered-word counter; flags the last word of a frame and wraps on it.
module dispatch_frame_counter #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output logic terminal
);
    logic [CNT_W-1:0] cnt_q;

    assign terminal = (cnt_q == CNT_W'(FRAME_LEN - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= terminal ? '0 : cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/result_dispatcher.sv
// Pops tagged result words and returns each to master 0 or 1 with per-master frame counting.
// Optional build macro RESULT_DISPATCHER_TIMEOUT_EN drops words a master leaves waiting too long.
module result_dispatcher
    import result_dispatcher_pkg::*;
#(
    parameter int unsigned DW        = RD_DW,
    parameter int unsigned PVW       = RD_PVW,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned CNT_W     = $clog2(FRAME_LEN + 1),
    parameter int unsigned TIMEOUT   = 256
) (
    input logic                 clk,
    input logic                 rst,
    result_dispatcher_if.master bus
);
    localparam int unsigned SrcBit = DW + PVW + 2;

    if (FRAME_LEN < 1 || TIMEOUT < 1) begin : gen_param_check
        $error("result_dispatcher: FRAME_LEN and TIMEOUT must be >= 1");
    end

    disp_state_t    state_q;
    logic           rd_en_q, src_q, valid0_q, valid1_q, cmplt0_q, cmplt1_q, drop_q;
    logic [1:0]     mode_q;
    logic [PVW-1:0] pv_q;
    logic [DW-1:0]  data_q;

    logic           dout_src;
    logic [1:0]     dout_mode;
    logic           handshake, inc0, inc1, term0, term1, term_sel;

    assign dout_src  = bus.fifo_dout[SrcBit];
    assign dout_mode = bus.fifo_dout[SrcBit-1 -: 2];

    // Only the addressed master's ready matters; the other one is ignored.
    assign handshake = (state_q == StSend) && (src_q ? bus.mstr1_ready : bus.mstr0_ready);
    assign inc0      = handshake && !src_q;
    assign inc1      = handshake && src_q;
    assign term_sel  = src_q ? term1 : term0;

    dispatch_frame_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt0 (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc0),
        .terminal (term0)
    );

    dispatch_frame_counter #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_cnt1 (
        .clk      (clk),
        .rst      (rst),
        .inc      (inc1),
        .terminal (term1)
    );

`ifdef RESULT_DISPATCHER_TIMEOUT_EN
    localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [WaitW-1:0] wait_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rd_en_q  <= 1'b0;
            src_q    <= 1'b0;
            mode_q   <= '0;
            pv_q     <= '0;
            data_q   <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            cmplt0_q <= 1'b0;
            cmplt1_q <= 1'b0;
            drop_q   <= 1'b0;
`ifdef RESULT_DISPATCHER_TIMEOUT_EN
            wait_q   <= '0;
`endif
        end else begin
            rd_en_q  <= 1'b0;
            drop_q   <= 1'b0;
            cmplt0_q <= 1'b0;
            cmplt1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!bus.fifo_empty) begin
                        state_q <= StFetch;
                        rd_en_q <= 1'b1;
                    end
                end
                StFetch: state_q <= StCapture;
                StCapture: begin
                    src_q  <= dout_src;
                    mode_q <= dout_mode;
                    pv_q   <= bus.fifo_dout[DW+PVW-1 -: PVW];
                    data_q <= bus.fifo_dout[DW-1:0];
                    if (dout_mode == 2'd0) begin
                        drop_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        valid0_q <= !dout_src;
                        valid1_q <= dout_src;
                        state_q  <= StSend;
`ifdef RESULT_DISPATCHER_TIMEOUT_EN
                        wait_q   <= '0;
`endif
                    end
                end
                StSend: begin
                    if (handshake) begin
                        valid0_q <= 1'b0;
                        valid1_q <= 1'b0;
                        if (term_sel) begin
                            state_q  <= StDone;
                            cmplt0_q <= !src_q;
                            cmplt1_q <= src_q;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
`ifdef RESULT_DISPATCHER_TIMEOUT_EN
                    else if (wait_q == WaitW'(TIMEOUT - 1)) begin
                        valid0_q <= 1'b0;
                        valid1_q <= 1'b0;
                        drop_q   <= 1'b1;
                        state_q  <= StIdle;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
`endif
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.fifo_rd_en       = rd_en_q;
    assign bus.mstr0_data       = data_q;
    assign bus.mstr0_mode       = mode_q;
    assign bus.mstr0_proc_val   = pv_q;
    assign bus.mstr0_data_valid = valid0_q;
    assign bus.mstr0_cmplt      = cmplt0_q;
    assign bus.mstr1_data       = data_q;
    assign bus.mstr1_mode       = mode_q;
    assign bus.mstr1_proc_val   = pv_q;
    assign bus.mstr1_data_valid = valid1_q;
    assign bus.mstr1_cmplt      = cmplt1_q;
    assign bus.drop_err         = drop_q;

endmodule

// File: tb/tb_result_dispatcher.sv
// Directed bench for result_dispatcher: a table of single-word vectors plus stall,
// timeout and mid-transfer reset sequences, against a small behavioural result FIFO.
module tb_result_dispatcher;
    import result_dispatcher_pkg::*;

    localparam int unsigned FRAME_LEN_P = 4;
    localparam int unsigned TIMEOUT_P   = 8;
`ifdef RESULT_DISPATCHER_TIMEOUT_EN
    localparam int STALL = 6;
`else
    localparam int STALL = 10;
`endif

    // exp_port: 0 or 1 for delivery, 2 for a dropped word
    typedef struct {
        res_word_t word;
        int        exp_port;
        bit        exp_cmplt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    result_dispatcher_if bus ();

    result_dispatcher #(
        .FRAME_LEN (FRAME_LEN_P),
        .TIMEOUT   (TIMEOUT_P)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    res_word_t fifo_mem [0:63];
    int        wr_ptr = 0;
    int        rd_ptr = 0;

    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            bus.fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr        <= rd_ptr + 1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input res_word_t w);
        fifo_mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_event(output bit seen, output int cycles);
        seen   = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.mstr0_data_valid || bus.mstr1_data_valid || bus.drop_err) seen = 1'b1;
        end
    endtask

    function automatic res_word_t mkw(input logic s, input logic [1:0] m,
                                      input logic [7:0] pv, input logic [31:0] d);
        res_word_t w;
        w.src = s; w.mode = m; w.proc_val = pv; w.data = d;
        return w;
    endfunction

    function automatic vec_t mk(input logic s, input logic [1:0] m, input logic [7:0] pv,
                                input logic [31:0] d, input int port, input bit c);
        vec_t v;
        v.word = mkw(s, m, pv, d);
        v.exp_port = port;
        v.exp_cmplt = c;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        bit seen;
        int cyc;
        push(v.word);
        wait_event(seen, cyc);
        check($sformatf("v%0d_seen", idx), 64'(seen), 64'd1);
        if (!seen) return;
        check($sformatf("v%0d_latency", idx), 64'(cyc), 64'd3);
        if (v.exp_port == 2) begin
            check($sformatf("v%0d_drop", idx), 64'(bus.drop_err), 64'd1);
            check($sformatf("v%0d_valid0", idx), 64'(bus.mstr0_data_valid), 64'd0);
            check($sformatf("v%0d_valid1", idx), 64'(bus.mstr1_data_valid), 64'd0);
        end else begin
            check($sformatf("v%0d_valid0", idx), 64'(bus.mstr0_data_valid), 64'(v.exp_port == 0));
            check($sformatf("v%0d_valid1", idx), 64'(bus.mstr1_data_valid), 64'(v.exp_port == 1));
            check($sformatf("v%0d_drop", idx), 64'(bus.drop_err), 64'd0);
            if (v.exp_port == 0) begin
                check($sformatf("v%0d_data", idx), 64'(bus.mstr0_data), 64'(v.word.data));
                check($sformatf("v%0d_mode", idx), 64'(bus.mstr0_mode), 64'(v.word.mode));
                check($sformatf("v%0d_pv", idx), 64'(bus.mstr0_proc_val), 64'(v.word.proc_val));
            end else begin
                check($sformatf("v%0d_data", idx), 64'(bus.mstr1_data), 64'(v.word.data));
                check($sformatf("v%0d_mode", idx), 64'(bus.mstr1_mode), 64'(v.word.mode));
                check($sformatf("v%0d_pv", idx), 64'(bus.mstr1_proc_val), 64'(v.word.proc_val));
            end
        end
        @(negedge clk);
        check($sformatf("v%0d_cmplt0", idx), 64'(bus.mstr0_cmplt),
              64'(v.exp_cmplt && v.exp_port == 0));
        check($sformatf("v%0d_cmplt1", idx), 64'(bus.mstr1_cmplt),
              64'(v.exp_cmplt && v.exp_port == 1));
        check($sformatf("v%0d_valid_off", idx),
              64'(bus.mstr0_data_valid | bus.mstr1_data_valid), 64'd0);
        check($sformatf("v%0d_drop_off", idx), 64'(bus.drop_err), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d_cmplt_off", idx), 64'(bus.mstr0_cmplt | bus.mstr1_cmplt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        bit   seen;
        int   cyc;
        int   hi;

        // Hand-computed: FRAME_LEN=4, the reset-test word already counts once for master 0.
        vecs[0]  = mk(1'b0, 2'd1, 8'h11, 32'hA5A5_0001, 0, 1'b0); // cnt0 -> 2
        vecs[1]  = mk(1'b1, 2'd2, 8'h22, 32'h0000_BEEF, 1, 1'b0); // cnt1 -> 1
        vecs[2]  = mk(1'b0, 2'd0, 8'h33, 32'hDEAD_0000, 2, 1'b0); // dropped, cnt0 stays 2
        vecs[3]  = mk(1'b0, 2'd3, 8'h44, 32'h1234_5678, 0, 1'b0); // cnt0 -> 3
        vecs[4]  = mk(1'b1, 2'd1, 8'h55, 32'h5555_AAAA, 1, 1'b0); // cnt1 -> 2
        vecs[5]  = mk(1'b0, 2'd2, 8'h66, 32'h0F0F_0F0F, 0, 1'b1); // frame 0 done
        vecs[6]  = mk(1'b1, 2'd0, 8'h77, 32'hFFFF_FFFF, 2, 1'b0); // dropped
        vecs[7]  = mk(1'b1, 2'd3, 8'h88, 32'h8000_0001, 1, 1'b0); // cnt1 -> 3
        vecs[8]  = mk(1'b1, 2'd1, 8'h99, 32'h0000_0000, 1, 1'b1); // frame 1 done
        vecs[9]  = mk(1'b0, 2'd1, 8'hA1, 32'h0000_0A01, 0, 1'b0); // cnt0 restarted: 1
        vecs[10] = mk(1'b0, 2'd1, 8'hA2, 32'h0000_0A02, 0, 1'b0);
        vecs[11] = mk(1'b0, 2'd1, 8'hA3, 32'h0000_0A03, 0, 1'b0);
        vecs[12] = mk(1'b0, 2'd1, 8'hA4, 32'h0000_0A04, 0, 1'b1); // second frame 0 done

        bus.mstr0_ready = 1'b1;
        bus.mstr1_ready = 1'b1;

        // Reset with the FIFO already non-empty.
        push(mkw(1'b0, 2'd1, 8'h5A, 32'h0000_0001));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
            check("rst_valids", 64'({bus.mstr0_data_valid, bus.mstr1_data_valid}), 64'd0);
            check("rst_cmplt_drop", 64'({bus.mstr0_cmplt, bus.mstr1_cmplt, bus.drop_err}), 64'd0);
            check("rst_data", 64'({bus.mstr0_data, bus.mstr1_data}), 64'd0);
            check("rst_mode_pv", 64'({bus.mstr0_mode, bus.mstr0_proc_val,
                                      bus.mstr1_mode, bus.mstr1_proc_val}), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rd_en", 64'(bus.fifo_rd_en), 64'd1);
        @(negedge clk);
        check("post_rst_rd_en_once", 64'(bus.fifo_rd_en), 64'd0);
        check("post_rst_valid_early", 64'(bus.mstr0_data_valid), 64'd0);
        @(negedge clk);
        check("post_rst_valid0", 64'(bus.mstr0_data_valid), 64'd1);
        check("post_rst_data", 64'(bus.mstr0_data), 64'h0000_0001);
        @(negedge clk);
        check("post_rst_valid_off", 64'(bus.mstr0_data_valid), 64'd0);

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // Back-pressure on master 1 with a master-0 word queued behind it.
        bus.mstr1_ready = 1'b0;
        push(mkw(1'b1, 2'd1, 8'h77, 32'hCAFE_0001));
        push(mkw(1'b0, 2'd2, 8'h88, 32'h0BAD_0002));
        wait_event(seen, cyc);
        check("bp_seen", 64'(bus.mstr1_data_valid), 64'd1);
        for (int i = 0; i < STALL; i++) begin
            check("bp_valid1", 64'(bus.mstr1_data_valid), 64'd1);
            check("bp_data", 64'(bus.mstr1_data), 64'hCAFE_0001);
            check("bp_pv", 64'(bus.mstr1_proc_val), 64'h77);
            check("bp_valid0", 64'(bus.mstr0_data_valid), 64'd0);
            check("bp_no_fetch", 64'(bus.fifo_rd_en), 64'd0);
            check("bp_no_drop", 64'(bus.drop_err), 64'd0);
            if (i < STALL - 1) @(negedge clk);
        end
        bus.mstr1_ready = 1'b1;
        @(negedge clk);
        check("bp_released", 64'(bus.mstr1_data_valid), 64'd0);
        wait_event(seen, cyc);
        check("bp_next_valid0", 64'(bus.mstr0_data_valid), 64'd1);
        check("bp_next_data", 64'(bus.mstr0_data), 64'h0BAD_0002);
        check("bp_next_mode", 64'(bus.mstr0_mode), 64'd2);
        @(negedge clk);
        @(negedge clk);

`ifdef RESULT_DISPATCHER_TIMEOUT_EN
        // Master 0 never accepts: the word times out and the next one is fetched.
        bus.mstr0_ready = 1'b0;
        push(mkw(1'b0, 2'd1, 8'hC1, 32'h7100_0001));
        push(mkw(1'b1, 2'd3, 8'hC2, 32'h7100_0002));
        wait_event(seen, cyc);
        hi = 0;
        for (int i = 0; i < 20 && bus.mstr0_data_valid; i++) begin
            hi++;
            @(negedge clk);
        end
        check("to_valid_cycles", 64'(hi), 64'(TIMEOUT_P));
        check("to_drop", 64'(bus.drop_err), 64'd1);
        check("to_valid_off", 64'(bus.mstr0_data_valid), 64'd0);
        @(negedge clk);
        check("to_next_fetch", 64'(bus.fifo_rd_en), 64'd1);
        check("to_drop_once", 64'(bus.drop_err), 64'd0);
        bus.mstr0_ready = 1'b1;
        wait_event(seen, cyc);
        check("to_next_valid1", 64'(bus.mstr1_data_valid), 64'd1);
        check("to_next_data", 64'(bus.mstr1_data), 64'h7100_0002);
        @(negedge clk);
        @(negedge clk);
`endif

        // Reset while a word is held abandons it.
        bus.mstr0_ready = 1'b0;
        push(mkw(1'b0, 2'd1, 8'hE1, 32'hE000_0001));
        wait_event(seen, cyc);
        check("mid_rst_valid_before", 64'(bus.mstr0_data_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 64'(bus.mstr0_data_valid), 64'd0);
        check("mid_rst_data", 64'(bus.mstr0_data), 64'd0);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hi += int'(bus.fifo_rd_en) + int'(bus.mstr0_data_valid);
        end
        check("mid_rst_no_refetch", 64'(hi), 64'd0);
        bus.mstr0_ready = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
